// File: rtl/fm0_rx_pkg.sv
// Shared types and constants for the FM0 receive-frame controller.
package fm0_rx_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned NB_W   = 5;
  localparam int unsigned ST_W   = 3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARM       = 3'd1,
    S_WAIT_SYNC = 3'd2,
    S_RECV      = 3'd3,
    S_CHECK     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  localparam logic [ST_W-1:0] ST_OK       = 3'd0;
  localparam logic [ST_W-1:0] ST_NO_SYNC  = 3'd1;
  localparam logic [ST_W-1:0] ST_CODE_ERR = 3'd2;
  localparam logic [ST_W-1:0] ST_BIT_TO   = 3'd3;
  localparam logic [ST_W-1:0] ST_CRC_ERR  = 3'd4;
  localparam logic [ST_W-1:0] ST_BAD_LEN  = 3'd5;

  localparam logic [WORD_W-1:0] CRC_POLY    = 16'h1021;
  localparam logic [WORD_W-1:0] CRC_PRESET  = 16'hFFFF;
  localparam logic [WORD_W-1:0] CRC_RESIDUE = 16'h1D0F;

endpackage

// File: rtl/crc16_ser.sv
// Bit-serial CRC-16/CCITT, MSB first; clr_i loads the preset.
module crc16_ser
  import fm0_rx_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              bit_i,
  output logic [WORD_W-1:0] crc_o
);

  logic fb;
  assign fb = crc_o[WORD_W-1] ^ bit_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      crc_o <= '0;
    end else if (clr_i) begin
      crc_o <= CRC_PRESET;
    end else if (en_i) begin
      crc_o <= {crc_o[WORD_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
  end

endmodule

// File: rtl/fm0_rx_frame_ctrl.sv
// Sequences the FM0 decoder for one tag reply: lock wait, bit count,
// 16-bit word packing and CRC-16 check, ending in a single status.
module fm0_rx_frame_ctrl
  import fm0_rx_pkg::*;
#(
  parameter int unsigned     LEN_W  = 10,
  parameter int unsigned     TO_W   = 16,
  parameter logic [TO_W-1:0] BIT_TO = 16'd2000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  exp_len_i,
  input  logic              crc_en_i,
  input  logic [TO_W-1:0]   sync_to_i,
  output logic              dec_clr_o,
  input  logic              form_sync_i,
  input  logic              err_form_i,
  input  logic              form_valid_i,
  input  logic              form_data_i,
  output logic              busy_o,
  output logic              word_valid_o,
  output logic [WORD_W-1:0] word_o,
  output logic [NB_W-1:0]   word_nbits_o,
  output logic              word_last_o,
  output logic              done_o,
  output logic [ST_W-1:0]   status_o
);

  state_t              state;
  logic [LEN_W-1:0]    len_q;
  logic                crc_en_q;
  logic [TO_W-1:0]     sync_to_q;
  logic [TO_W-1:0]     timer;
  logic [LEN_W-1:0]    bit_cnt;
  logic [WORD_W-1:0]   wsh;
  logic [NB_W-1:0]     wn;
  logic [WORD_W-1:0]   crc;

  logic                bad_len;
  logic                bit_take;
  logic                last_bit;
  logic [WORD_W-1:0]   w_next;
  logic [NB_W-1:0]     wn_next;

  assign bad_len  = (exp_len_i == '0) || (crc_en_i && (exp_len_i < LEN_W'(WORD_W)));
  // A bit is consumed only in RECV and only when no coding error preempts it
  assign bit_take = (state == S_RECV) && form_valid_i && !err_form_i;
  assign last_bit = (bit_cnt == LEN_W'(1));
  assign w_next   = {wsh[WORD_W-2:0], form_data_i};
  assign wn_next  = wn + NB_W'(1);

  crc16_ser u_crc (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (state == S_ARM),
    .en_i  (bit_take),
    .bit_i (form_data_i),
    .crc_o (crc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      len_q        <= '0;
      crc_en_q     <= 1'b0;
      sync_to_q    <= '0;
      timer        <= '0;
      bit_cnt      <= '0;
      wsh          <= '0;
      wn           <= '0;
      dec_clr_o    <= 1'b1;
      busy_o       <= 1'b0;
      word_valid_o <= 1'b0;
      word_o       <= '0;
      word_nbits_o <= '0;
      word_last_o  <= 1'b0;
      done_o       <= 1'b0;
      status_o     <= ST_OK;
    end else begin
      word_valid_o <= 1'b0;
      word_last_o  <= 1'b0;
      done_o       <= 1'b0;
      case (state)
        S_IDLE: begin
          dec_clr_o <= 1'b1;
          busy_o    <= 1'b0;
          if (start_i) begin
            len_q     <= exp_len_i;
            crc_en_q  <= crc_en_i;
            sync_to_q <= sync_to_i;
            busy_o    <= 1'b1;
            status_o  <= ST_OK;
            if (bad_len) begin
              state    <= S_DONE;
              done_o   <= 1'b1;
              status_o <= ST_BAD_LEN;
            end else begin
              state <= S_ARM;
            end
          end
        end
        S_ARM: begin
          timer     <= sync_to_q;
          bit_cnt   <= len_q;
          wsh       <= '0;
          wn        <= '0;
          dec_clr_o <= 1'b0;
          state     <= S_WAIT_SYNC;
        end
        S_WAIT_SYNC: begin
          if (form_sync_i) begin
            timer <= BIT_TO;
            state <= S_RECV;
          end else if (timer == '0) begin
            state     <= S_DONE;
            done_o    <= 1'b1;
            status_o  <= ST_NO_SYNC;
            dec_clr_o <= 1'b1;
          end else begin
            timer <= timer - TO_W'(1);
          end
        end
        S_RECV: begin
          if (err_form_i) begin
            state     <= S_DONE;
            done_o    <= 1'b1;
            status_o  <= ST_CODE_ERR;
            dec_clr_o <= 1'b1;
          end else if (form_valid_i) begin
            timer   <= BIT_TO;
            bit_cnt <= bit_cnt - LEN_W'(1);
            if ((wn_next == NB_W'(WORD_W)) || last_bit) begin
              word_o       <= w_next;
              word_nbits_o <= wn_next;
              word_valid_o <= 1'b1;
              word_last_o  <= last_bit;
              wsh          <= '0;
              wn           <= '0;
            end else begin
              wsh <= w_next;
              wn  <= wn_next;
            end
            if (last_bit) begin
              state <= S_CHECK;
            end
          end else if (timer == '0) begin
            state     <= S_DONE;
            done_o    <= 1'b1;
            status_o  <= ST_BIT_TO;
            dec_clr_o <= 1'b1;
          end else begin
            timer <= timer - TO_W'(1);
          end
        end
        S_CHECK: begin
          state     <= S_DONE;
          done_o    <= 1'b1;
          dec_clr_o <= 1'b1;
          status_o  <= (crc_en_q && (crc != CRC_RESIDUE)) ? ST_CRC_ERR : ST_OK;
        end
        S_DONE: begin
          state     <= S_IDLE;
          busy_o    <= 1'b0;
          dec_clr_o <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fm0_rx_frame_ctrl.sv
// Directed bench for fm0_rx_frame_ctrl.
module tb_fm0_rx_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  exp_len = '0;
  logic        crc_en = 1'b0;
  logic [15:0] sync_to = '0;
  logic        dec_clr;
  logic        form_sync = 1'b0;
  logic        err_form = 1'b0;
  logic        form_valid = 1'b0;
  logic        form_data = 1'b0;
  logic        busy;
  logic        word_valid;
  logic [15:0] word;
  logic [4:0]  nbits;
  logic        last;
  logic        done;
  logic [2:0]  status;

  int vectors = 0;
  int miscompares = 0;

  int          cyc = 0;
  int          nw = 0;
  int          ndone = 0;
  int          done_cyc = 0;
  int          fv_cyc = 0;
  int          st_cyc = 0;
  logic [2:0]  done_stat = '0;
  logic [15:0] wq [0:15];
  logic [4:0]  nbq [0:15];
  logic        lq [0:15];
  int          base_w = 0;
  int          base_d = 0;

  fm0_rx_frame_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .exp_len_i    (exp_len),
    .crc_en_i     (crc_en),
    .sync_to_i    (sync_to),
    .dec_clr_o    (dec_clr),
    .form_sync_i  (form_sync),
    .err_form_i   (err_form),
    .form_valid_i (form_valid),
    .form_data_i  (form_data),
    .busy_o       (busy),
    .word_valid_o (word_valid),
    .word_o       (word),
    .word_nbits_o (nbits),
    .word_last_o  (last),
    .done_o       (done),
    .status_o     (status)
  );

  always #5 clk = ~clk;

  // Output monitor on the falling edge so no strobe is missed
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (form_valid) fv_cyc <= cyc;
    if (start && !busy) st_cyc <= cyc;
    if (word_valid && nw < 16) begin
      wq[nw]  <= word;
      nbq[nw] <= nbits;
      lq[nw]  <= last;
      nw      <= nw + 1;
    end
    if (done) begin
      ndone     <= ndone + 1;
      done_cyc  <= cyc;
      done_stat <= status;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [9:0] len, input logic ce, input logic [15:0] sto);
    base_w  = nw;
    base_d  = ndone;
    exp_len = len;
    crc_en  = ce;
    sync_to = sto;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic lock();
    form_sync = 1'b1;
    step();
    step();
  endtask

  task automatic send_bits(input logic [31:0] val, input int n);
    logic [31:0] v;
    v = val;
    for (int i = n - 1; i >= 0; i--) begin
      form_data  = v[i];
      form_valid = 1'b1;
      step();
      form_valid = 1'b0;
      step();
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (ndone == base_d && n < budget) begin
      step();
      n++;
    end
    vectors++;
    if (ndone == base_d) begin
      $display("FAIL done_timeout: no done_o within %0d cycles", budget);
      miscompares++;
    end
    step();
    step();
    form_sync = 1'b0;
    err_form  = 1'b0;
  endtask

  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors++;
    if ({dec_clr, busy, word_valid, word, nbits, last, done, status} !== {1'b1, 1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 3'd0}) begin
      $display("FAIL reset_state: got clr=%b busy=%b wv=%b w=%h nb=%0d l=%b d=%b st=%0d", dec_clr, busy, word_valid, word, nbits, last, done, status);
      miscompares++;
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_rn16();
    start_frame(10'd16, 1'b0, 16'd500);
    repeat (100) step();
    vectors++;
    if ({busy, dec_clr} !== 2'b10) begin
      $display("FAIL rn16_wait_sync: busy=%b clr=%b expected busy=1 clr=0", busy, dec_clr);
      miscompares++;
    end
    lock();
    send_bits(32'hA5C3, 16);
    wait_done(50);
    vectors++;
    if (nw - base_w != 1 || wq[base_w] !== 16'hA5C3 || nbq[base_w] !== 5'd16 || lq[base_w] !== 1'b1) begin
      $display("FAIL rn16_word: count=%0d w=%h nb=%0d l=%b expected 1 a5c3 16 1", nw - base_w, wq[base_w], nbq[base_w], lq[base_w]);
      miscompares++;
    end
    vectors++;
    if (done_cyc - fv_cyc != 2 || done_stat !== 3'd0) begin
      $display("FAIL rn16_done: latency=%0d status=%0d expected 2 0", done_cyc - fv_cyc, done_stat);
      miscompares++;
    end
    vectors++;
    if ({busy, dec_clr} !== 2'b01) begin
      $display("FAIL rn16_idle: busy=%b clr=%b expected busy=0 clr=1", busy, dec_clr);
      miscompares++;
    end
  endtask

  task automatic test_crc(input logic flip);
    logic [15:0] pay;
    logic [15:0] c;
    logic [31:0] frame;
    pay = 16'h1234;
    c = 16'hFFFF;
    for (int i = 15; i >= 0; i--) c = crc_bit(c, pay[i]);
    frame = {pay, ~c};
    if (flip) frame[20] = ~frame[20];
    start_frame(10'd32, 1'b1, 16'd500);
    lock();
    send_bits(frame, 32);
    wait_done(50);
    vectors++;
    if (nw - base_w != 2 || wq[base_w] !== frame[31:16] || wq[base_w+1] !== frame[15:0] ||
        lq[base_w] !== 1'b0 || lq[base_w+1] !== 1'b1) begin
      $display("FAIL crc_words flip=%b: count=%0d w0=%h w1=%h l0=%b l1=%b expected 2 %h %h 0 1",
               flip, nw - base_w, wq[base_w], wq[base_w+1], lq[base_w], lq[base_w+1], frame[31:16], frame[15:0]);
      miscompares++;
    end
    vectors++;
    if (done_stat !== (flip ? 3'd4 : 3'd0)) begin
      $display("FAIL crc_status flip=%b: got %0d expected %0d", flip, done_stat, flip ? 4 : 0);
      miscompares++;
    end
  endtask

  task automatic test_no_sync();
    start_frame(10'd16, 1'b0, 16'd50);
    repeat (10) step();
    exp_len = 10'd0;
    start   = 1'b1;
    step();
    start   = 1'b0;
    wait_done(200);
    vectors++;
    if (done_cyc - st_cyc != 53 || done_stat !== 3'd1 || nw != base_w || ndone - base_d != 1) begin
      $display("FAIL no_sync: delay=%0d status=%0d words=%0d dones=%0d expected 53 1 0 1",
               done_cyc - st_cyc, done_stat, nw - base_w, ndone - base_d);
      miscompares++;
    end
  endtask

  task automatic test_20bit();
    start_frame(10'd20, 1'b0, 16'd500);
    lock();
    send_bits(32'hABCDE, 20);
    wait_done(50);
    vectors++;
    if (nw - base_w != 2 || wq[base_w] !== 16'hABCD || nbq[base_w] !== 5'd16 || lq[base_w] !== 1'b0) begin
      $display("FAIL w20_first: count=%0d w=%h nb=%0d l=%b expected 2 abcd 16 0", nw - base_w, wq[base_w], nbq[base_w], lq[base_w]);
      miscompares++;
    end
    vectors++;
    if (wq[base_w+1] !== 16'h000E || nbq[base_w+1] !== 5'd4 || lq[base_w+1] !== 1'b1 || done_stat !== 3'd0) begin
      $display("FAIL w20_second: w=%h nb=%0d l=%b st=%0d expected 000e 4 1 0", wq[base_w+1], nbq[base_w+1], lq[base_w+1], done_stat);
      miscompares++;
    end
  endtask

  task automatic test_code_err();
    start_frame(10'd32, 1'b0, 16'd500);
    lock();
    send_bits(32'h15, 5);
    err_form = 1'b1;
    wait_done(20);
    vectors++;
    if (done_stat !== 3'd2 || nw != base_w) begin
      $display("FAIL code_err: status=%0d words=%0d expected 2 0", done_stat, nw - base_w);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    start_frame(10'd16, 1'b0, 16'd500);
    lock();
    send_bits(32'h0F0F, 16);
    wait_done(50);
    vectors++;
    if (done_stat !== 3'd0 || nw - base_w != 1 || wq[base_w] !== 16'h0F0F) begin
      $display("FAIL after_err: status=%0d words=%0d w=%h expected 0 1 0f0f", done_stat, nw - base_w, wq[base_w]);
      miscompares++;
    end
  endtask

  task automatic test_bit_to();
    start_frame(10'd16, 1'b0, 16'd500);
    lock();
    send_bits(32'h3FF, 10);
    wait_done(3000);
    vectors++;
    if (done_stat !== 3'd3 || nw != base_w || done_cyc - fv_cyc != 2002) begin
      $display("FAIL bit_to: status=%0d words=%0d gap=%0d expected 3 0 2002", done_stat, nw - base_w, done_cyc - fv_cyc);
      miscompares++;
    end
  endtask

  task automatic test_bad_len();
    start_frame(10'd8, 1'b1, 16'd500);
    wait_done(10);
    vectors++;
    if (done_stat !== 3'd5 || done_cyc - st_cyc != 1 || nw != base_w) begin
      $display("FAIL bad_len_crc: status=%0d delay=%0d words=%0d expected 5 1 0", done_stat, done_cyc - st_cyc, nw - base_w);
      miscompares++;
    end
    start_frame(10'd0, 1'b0, 16'd500);
    wait_done(10);
    vectors++;
    if (done_stat !== 3'd5) begin
      $display("FAIL bad_len_zero: status=%0d expected 5", done_stat);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    start_frame(10'd32, 1'b0, 16'd500);
    lock();
    send_bits(32'h1F, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if ({dec_clr, busy, word_valid, word, nbits, last, done, status} !== {1'b1, 1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 3'd0}) begin
      $display("FAIL reset_mid: got clr=%b busy=%b wv=%b w=%h nb=%0d l=%b d=%b st=%0d", dec_clr, busy, word_valid, word, nbits, last, done, status);
      miscompares++;
    end
    form_sync = 1'b0;
    repeat (20) step();
    vectors++;
    if (ndone != base_d) begin
      $display("FAIL reset_mid_done: dones=%0d expected 0", ndone - base_d);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_rn16();
    test_crc(1'b0);
    test_crc(1'b1);
    test_no_sync();
    test_20bit();
    test_code_err();
    test_back_to_back();
    test_bit_to();
    test_bad_len();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fm0_rx_frame_ctrl.md
Name: fm0_rx_frame_ctrl

Overview:
Receive-frame controller that sequences the FM0 decoder for one tag reply. When armed after a reader command, it clears the decoder and waits for preamble lock with a timeout. It then counts the expected number of decoded bits, packs them into 16-bit words, and checks the Gen2 CRC-16. It reports a single completion status to the protocol FSM. It sits between the FM0 decoder and the link-layer/protocol controller in the Rx channel.

Parameters:
LEN_W, 10, width of expected bit-length field (max 1023 bits)
TO_W, 16, width of timeout counters
BIT_TO, 16'd2000, max clk cycles allowed between consecutive decoded bits once locked
CRC_RESIDUE, 16'h1D0F, CRC-16/CCITT residue indicating a good frame

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous, active-high reset
start_i  in  1  one-cycle pulse: arm reception (ignored unless IDLE)
exp_len_i  in  LEN_W  expected payload bits incl. CRC; sampled on start_i
crc_en_i  in  1  1 = check CRC-16 over the frame; sampled on start_i
sync_to_i  in  TO_W  preamble-lock timeout in cycles; sampled on start_i
dec_clr_o  out  1  decoder clear, active-high; inverted externally to the decoder rst_n_i
form_sync_i  in  1  decoder preamble locked
err_form_i  in  1  decoder FM0 coding violation (sticky until clear)
form_valid_i  in  1  one-cycle decoded-bit strobe
form_data_i  in  1  decoded bit
busy_o  out  1  high in every state except IDLE
word_valid_o  out  1  one-cycle strobe: word_o valid
word_o  out  16  packed bits, first-received bit at MSB of the used field, right-aligned
word_nbits_o  out  5  valid bits in word_o (1..16)
word_last_o  out  1  with word_valid_o: final word of frame
done_o  out  1  one-cycle completion pulse
status_o  out  3  result, held from done_o until the next start_i

Behaviour:
- Reset: state IDLE, dec_clr_o=1, busy_o=0, word_valid_o=0, word_o=0, word_nbits_o=0, word_last_o=0, done_o=0, status_o=ST_OK. All counters and the CRC are cleared.
- Status codes: ST_OK=0, ST_NO_SYNC=1, ST_CODE_ERR=2, ST_BIT_TO=3, ST_CRC_ERR=4, ST_BAD_LEN=5.
- IDLE: dec_clr_o=1. On start_i, latch exp_len/crc_en/sync_to. If exp_len_i==0, or crc_en_i=1 with exp_len_i<16, go to DONE with ST_BAD_LEN. Otherwise go to ARM.
- ARM (1 cycle): dec_clr_o=1. Load timer=sync_to, bit counter=exp_len, crc=16'hFFFF, word shifter empty. Next state is WAIT_SYNC.
- WAIT_SYNC: dec_clr_o=0. form_sync_i=1 moves to RECV. Otherwise timer decrements, and when it reaches 0 the FSM goes to DONE with ST_NO_SYNC. sync_to_i=0 times out on the first WAIT_SYNC cycle unless sync is already high.
- RECV: timer reloads to BIT_TO on entry and on every form_valid_i, and decrements otherwise.
  - Each form_valid_i: shift bit into the word register, update the CRC (poly 0x1021, MSB first), decrement the bit counter.
  - When 16 bits are collected, or on the final bit, emit word_valid_o the next cycle with the word and its nbits. word_last_o is set on the final word.
  - Priority within one cycle: err_form_i, then final bit, then timer expiry.
  - err_form_i=1 goes to DONE with ST_CODE_ERR; a pending partial word is discarded and no word_last_o is emitted.
  - Timer reaching 0 goes to DONE with ST_BIT_TO; same discard rule.
  - Final bit goes to CHECK. An err_form_i in the same cycle as the final bit wins with ST_CODE_ERR.
- CHECK (1 cycle): if crc_en is set and crc != CRC_RESIDUE, result is ST_CRC_ERR; else ST_OK. Next state is DONE. The final word_valid_o coincides with this cycle.
- DONE (1 cycle): done_o=1, status_o updated, dec_clr_o=1. Next state is IDLE.
- Latency: last form_valid_i to done_o is 2 cycles.
- start_i while busy is ignored; no abort input. A decoder form_valid_i arriving in any state other than RECV is ignored.
- rst_i mid-frame returns everything to reset values in the next cycle; no done_o is produced.

Decomposition:
- Package fm0_rx_pkg holds the state enum, status codes ST_*, CRC_POLY=16'h1021, CRC_PRESET=16'hFFFF, and CRC_RESIDUE.
- One sub-module, crc16_ser: a serial CRC-16 with clear, enable, data bit and a 16-bit crc output.
- FSM, timers and word packer stay in the top module.

Test Plan:
1. RN16 without CRC: start exp_len=16, crc_en=0, sync_to=500; lock after 100 cycles; 16 bits of 0xA5C3 → one word 0xA5C3, nbits=16, last=1; done_o 2 cycles after the last bit; status=0.
2. 32-bit frame (16-bit payload plus correct CRC-16 from preset FFFF), crc_en=1 → words payload then CRC, last on the second word, status=0. Repeat with one payload bit flipped → status=4.
3. No lock: sync_to=50, form_sync_i held 0 → done_o at cycle ~51 after ARM, status=1, no word_valid_o.
4. 20-bit frame, crc_en=0 → word 1 nbits=16 last=0; word 2 nbits=4, right-aligned, last=1; status=0.
5. err_form_i rises after bit 5 → status=2, no word output; a second start works normally afterwards.
6. Bit gap greater than BIT_TO after bit 10 → status=3. Also: start with exp_len=8 and crc_en=1 → status=5 with no ARM; rst_i mid-RECV → outputs return to reset and no done_o.
